// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path.
// Build macro MC_BNE_EN adds the bne opcode and its BNE state.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
`ifdef MC_BNE_EN
    ,
    S_BNE      = 4'd12
`endif
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: state -> full control word, no inputs involved.
// Build macro MC_BNE_EN adds the BNE state (same word as BRANCH).
module mc_output_decode
  import mips_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Map each state to its control word; unused encodings drive all zero
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.irwrite = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMM2;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNE,
`endif
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle MIPS control FSM: state register, dispatch and pcen.
// Build macro MC_BNE_EN enables bne (opcode 000101) via a BNE state.
module multicycle_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   taken;

  // Next-state: opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(opcode))
          state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)
          state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)
          state_d = S_BRANCH;
        else if (opcode == OP_ADDI)
          state_d = S_ADDIEXEC;
        else if (opcode == OP_J)
          state_d = S_JUMP;
`ifdef MC_BNE_EN
        else if (opcode == OP_BNE)
          state_d = S_BNE;
`endif
        else
          state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (opcode == OP_SW)
          state_d = S_MEMWR;
        else
          state_d = S_MEMRD;
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset parks in FETCH so outputs show FETCH values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  mc_output_decode u_dec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Branch condition: only combinational input-to-output path
  always_comb begin
    taken = zero;
`ifdef MC_BNE_EN
    if (state_q == S_BNE)
      taken = ~zero;
`endif
  end

  assign pcen     = ctrl.pcwrite | (ctrl.branch & taken);
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed + random opcodes.
// Reference model honours MC_BNE_EN when defined.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;

  multicycle_control_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .zero     (zero),
    .pcen     (pcen),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] w;
    logic [5:0]  op;
    int          idx;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 0;

  // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,
  //  alusrcb,pcsrc,aluop}
  function automatic logic [13:0] w(
    bit pe, bit mw, bit irw, bit rw, bit io, bit m2r, bit rd, bit sa,
    logic [1:0] sb_, logic [1:0] ps, logic [1:0] ao);
    return {pe, mw, irw, rw, io, m2r, rd, sa, sb_, ps, ao};
  endfunction

  function automatic logic [13:0] dut_w();
    return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
            alusrca, alusrcb, pcsrc, aluop};
  endfunction

  task automatic chk(string name, logic [13:0] got, logic [13:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents one control word
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got %b want <none>", dut_w());
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (dut_w() !== e.w) begin
          n_err++;
          $display("FAIL inst%0d op=%b cyc%0d: got %b want %b",
                   e.idx, e.op, e.cyc, dut_w(), e.w);
        end
      end
    end
  end

  int inst_no = 0;

  // Per-instruction expected control words straight from the ISA table
  task automatic issue(logic [5:0] op, bit z);
    logic [13:0] seq[$];
    bit bne_on;
    bne_on = 0;
`ifdef MC_BNE_EN
    bne_on = 1;
`endif
    opcode = op;
    zero   = z;
    seq.push_back(w(1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00));
    seq.push_back(w(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00));
    if (op == 6'b100011) begin
      seq.push_back(w(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00));
      seq.push_back(w(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00));
      seq.push_back(w(0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00));
    end else if (op == 6'b101011) begin
      seq.push_back(w(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00));
      seq.push_back(w(0,1,0,0,1,0,0,0,2'b00,2'b00,2'b00));
    end else if (op == 6'b000000) begin
      seq.push_back(w(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10));
      seq.push_back(w(0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00));
    end else if (op == 6'b000100) begin
      seq.push_back(w(z,0,0,0,0,0,0,1,2'b00,2'b01,2'b01));
    end else if (op == 6'b000101 && bne_on) begin
      seq.push_back(w(!z,0,0,0,0,0,0,1,2'b00,2'b01,2'b01));
    end else if (op == 6'b001000) begin
      seq.push_back(w(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00));
      seq.push_back(w(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00));
    end else if (op == 6'b000010) begin
      seq.push_back(w(1,0,0,0,0,0,0,0,2'b00,2'b10,2'b00));
    end
    for (int i = 0; i < seq.size(); i++) begin
      exp_t e;
      e.w   = seq[i];
      e.op  = op;
      e.idx = inst_no;
      e.cyc = i + 1;
      sb.push_back(e);
    end
    inst_no++;
    mon_en = 1;
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  logic [13:0] fetch_w;
  logic [5:0]  fixed_ops[8];

  initial begin
    fetch_w = w(1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00);
    fixed_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                  6'b000101, 6'b001000, 6'b000010, 6'b111111};
    rst_n  = 1'b0;
    opcode = 6'b100011;
    zero   = 1'b1;
    #1;
    chk("reset_async", dut_w(), fetch_w);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", dut_w(), fetch_w);
    rst_n = 1'b1;

    issue(6'b100011, 0);
    issue(6'b000000, 0);
    issue(6'b000100, 1);
    issue(6'b000100, 0);
    issue(6'b101011, 1);
    issue(6'b000010, 0);
    issue(6'b111111, 1);
    issue(6'b000101, 0);
    issue(6'b000101, 1);
    issue(6'b001000, 1);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0)
        op = 6'($urandom);
      else
        op = fixed_ops[$urandom_range(0, 7)];
      issue(op, 1'($urandom));
    end

    mon_en = 0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    end

    // Reset dropped mid-store must kill memwrite without a clock edge
    opcode = 6'b101011;
    zero   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("memwr_state", dut_w(), w(0,1,0,0,1,0,0,0,2'b00,2'b00,2'b00));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_midwr", dut_w(), fetch_w);
    @(posedge clk);
    #1;
    chk("reset_midwr_hold", dut_w(), fetch_w);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_decode", dut_w(),
        w(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
